// File: rtl/hangman_game_ctrl.sv
// Hangman game controller: latches the secret word, accepts letter guesses over valid/ready,
// and keeps the guessed-letter mask and miss count for the downstream VGA renderer.
module hangman_game_ctrl #(
  parameter int MAX_WRONG = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [29:0] word_in,
  input  logic        guess_valid,
  input  logic [4:0]  guess_letter,
  output logic        guess_ready,
  output logic [1:0]  game_state,
  output logic [29:0] word,
  output logic [25:0] mask,
  output logic [3:0]  wrong_count,
  output logic        result_valid,
  output logic [1:0]  result_code
);

  typedef enum logic [2:0] {IDLE, PLAY, EVAL, WIN, LOST} state_t;

  localparam logic [1:0] GS_START = 2'd0;
  localparam logic [1:0] GS_INGAME = 2'd1;
  localparam logic [1:0] GS_WIN = 2'd2;
  localparam logic [1:0] GS_LOST = 2'd3;

  localparam logic [1:0] RC_HIT = 2'd0;
  localparam logic [1:0] RC_MISS = 2'd1;
  localparam logic [1:0] RC_REPEAT = 2'd2;
  localparam logic [1:0] RC_INVALID = 2'd3;

  localparam logic [3:0] MAX_W = 4'(MAX_WRONG);

  state_t state;

  logic [25:0] letter_bit;
  logic        letter_invalid;
  logic        letter_repeat;
  logic        letter_in_word;
  logic        all_revealed;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_W) ? MAX_W : v + 4'd1;
  endfunction

  // Padding slots (code >= 26) neither match a guess nor need revealing.
  always_comb begin
    letter_bit     = 26'd1 << guess_letter;
    letter_invalid = (guess_letter >= 5'd26);
    letter_repeat  = |(mask & letter_bit);
    letter_in_word = 1'b0;
    all_revealed   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (word[5*i +: 5] < 5'd26) begin
        if (word[5*i +: 5] == guess_letter) letter_in_word = 1'b1;
        if (!mask[word[5*i +: 5]]) all_revealed = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      game_state   <= GS_START;
      guess_ready  <= 1'b0;
      word         <= '0;
      mask         <= '0;
      wrong_count  <= '0;
      result_valid <= 1'b0;
      result_code  <= RC_HIT;
    end else begin
      result_valid <= 1'b0;
      if (start) begin
        word        <= word_in;
        mask        <= '0;
        wrong_count <= '0;
        state       <= EVAL;
        game_state  <= GS_INGAME;
        guess_ready <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (guess_valid) begin
              result_valid <= 1'b1;
              if (letter_invalid) begin
                result_code <= RC_INVALID;
              end else if (letter_repeat) begin
                result_code <= RC_REPEAT;
              end else begin
                mask        <= mask | letter_bit;
                state       <= EVAL;
                guess_ready <= 1'b0;
                if (letter_in_word) begin
                  result_code <= RC_HIT;
                end else begin
                  result_code <= RC_MISS;
                  wrong_count <= sat_inc(wrong_count);
                end
              end
            end
          end
          EVAL: begin
            if (wrong_count >= MAX_W) begin
              state      <= LOST;
              game_state <= GS_LOST;
            end else if (all_revealed) begin
              state      <= WIN;
              game_state <= GS_WIN;
            end else begin
              state       <= PLAY;
              game_state  <= GS_INGAME;
              guess_ready <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
